// File: rtl/tnn_pkg.sv
// Shared types for the TNN feature front-ends: 3-bit feature codes,
// the (a, b, c) operand vector and the beat index of a vector.
package tnn_pkg;

  localparam int FEAT_W   = 3;
  localparam int NUM_FEAT = 3;
  localparam int FEAT_MAX = (1 << FEAT_W) - 1;

  typedef logic [FEAT_W-1:0] feat_t;

  typedef struct packed {
    feat_t a;
    feat_t b;
    feat_t c;
  } feat_vec_t;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } beat_idx_e;

endpackage

// File: rtl/tnn_quant_unit.sv
// Combinational quantizer: subtract an offset, shift right, clamp to the
// feature code range. Negative differences map to code 0.
module tnn_quant_unit
  import tnn_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] OFFSET = 16,
  parameter int                SHIFT  = 4
) (
  input  logic [DATA_W-1:0] data,
  output feat_t             q
);

  logic signed [DATA_W:0] diff;
  logic [DATA_W-1:0]      shifted;

  // One extra bit keeps the subtraction sign-correct for any sample value.
  assign diff    = $signed({1'b0, data}) - $signed({1'b0, OFFSET});
  assign shifted = diff[DATA_W-1:0] >> SHIFT;

  always_comb begin
    q = '0;
    if (!diff[DATA_W]) begin
      if (shifted > DATA_W'(FEAT_MAX)) begin
        q = feat_t'(FEAT_MAX);
      end else begin
        q = shifted[FEAT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tnn_feature_framer.sv
// Groups quantized samples into (a, b, c) operand vectors for the TNN
// neuron cores, with framing-error detection and a one-deep output register.
module tnn_feature_framer
  import tnn_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] OFFSET = 16,
  parameter int                SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2:0]        m_a,
  output logic [2:0]        m_b,
  output logic [2:0]        m_c,
  output logic [7:0]        err_cnt
);

  beat_idx_e idx_reg, idx_next;
  feat_t     hold_a_reg, hold_a_next;
  feat_t     hold_b_reg, hold_b_next;
  feat_vec_t out_reg, out_next;
  logic      m_valid_reg, m_valid_next;
  logic [7:0] err_cnt_reg, err_cnt_next;
  logic      err_inc;
  logic      accept;
  feat_t     q;

  tnn_quant_unit #(
    .DATA_W (DATA_W),
    .OFFSET (OFFSET),
    .SHIFT  (SHIFT)
  ) u_quant (
    .data (s_data),
    .q    (q)
  );

  // Only the closing beat can be blocked, and only by an undrained vector.
  assign s_ready = (idx_reg != COL2) | ~m_valid_reg | m_ready;
  assign accept  = s_valid & s_ready;

  always_comb begin
    idx_next     = idx_reg;
    hold_a_next  = hold_a_reg;
    hold_b_next  = hold_b_reg;
    out_next     = out_reg;
    m_valid_next = m_valid_reg & ~m_ready;
    err_inc      = 1'b0;

    if (accept) begin
      unique case (idx_reg)
        COL0: begin
          if (s_last) begin
            err_inc  = 1'b1;
            idx_next = COL0;
          end else begin
            hold_a_next = q;
            idx_next    = COL1;
          end
        end
        COL1: begin
          if (s_last) begin
            err_inc  = 1'b1;
            idx_next = COL0;
          end else begin
            hold_b_next = q;
            idx_next    = COL2;
          end
        end
        COL2: begin
          idx_next = COL0;
          if (s_last) begin
            out_next     = '{a: hold_a_reg, b: hold_b_reg, c: q};
            m_valid_next = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
        default: idx_next = COL0;
      endcase
    end
  end

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_inc && (err_cnt_reg != 8'hFF)) begin
      err_cnt_next = err_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg     <= COL0;
      hold_a_reg  <= '0;
      hold_b_reg  <= '0;
      out_reg     <= '0;
      m_valid_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      idx_reg     <= idx_next;
      hold_a_reg  <= hold_a_next;
      hold_b_reg  <= hold_b_next;
      out_reg     <= out_next;
      m_valid_reg <= m_valid_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  assign m_valid = m_valid_reg;
  assign m_a     = out_reg.a;
  assign m_b     = out_reg.b;
  assign m_c     = out_reg.c;
  assign err_cnt = err_cnt_reg;

endmodule
